sp_ram_responder: RTL and testbench

Request/response responder that puts a valid/ready handshake in front of an inferred single-port block RAM. Initiators issue read or write requests. Each accepted request returns exactly one in-order response: read data, or a write acknowledgement. The block sits between the on-chip memory test initiators or bus bridges and one BSRAM instance. It absorbs response backpressure without losing data and sustains one request per cycle.

---
 rtl/sp_ram_responder.sv | 134 +++++++++++++
 tb/tb_sp_ram_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_responder.sv
// Valid/ready request/response front end for one inferred single-port byte RAM, with a stage + skid response buffer.
// Define SP_RAM_RESPONDER_INIT_EN to preset the first INIT_BYTES bytes to all ones.
module sp_ram_responder #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int INIT_BYTES = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata
);

  // state  | meaning
  // IDLE   | no response outstanding
  // ONE    | one response, held in the stage register
  // TWO    | older response in skid, newer in stage; no new requests
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} state_t;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_t r_state;
  state_t w_state_next;

`ifdef SP_RAM_RESPONDER_INIT_EN
  typedef logic [DATA_WIDTH-1:0] mem_t [0:DEPTH-1];

  function automatic mem_t f_mem_init();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = (i < INIT_BYTES) ? '1 : 'x;
    end
    return m;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1] = f_mem_init();
`else
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
`endif

  logic [DATA_WIDTH-1:0] r_ram_q;
  logic                  r_stage_write;
  logic                  r_skid_write;
  logic [DATA_WIDTH-1:0] r_skid_data;

  logic                  w_accept;
  logic                  w_consume;
  logic [DATA_WIDTH-1:0] w_stage_data;

  assign w_accept     = req_valid && req_ready;
  assign w_consume    = rsp_valid && rsp_ready;
  assign w_stage_data = r_stage_write ? '0 : r_ram_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_ONE;
      ST_ONE: begin
        if (w_accept && !w_consume)      w_state_next = ST_TWO;
        else if (!w_accept && w_consume) w_state_next = ST_IDLE;
      end
      ST_TWO:  if (w_consume) w_state_next = ST_ONE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_write = 1'b0;
    rsp_rdata = '0;
    case (r_state)
      ST_IDLE: req_ready = !reset;
      ST_ONE: begin
        req_ready = !reset;
        rsp_valid = 1'b1;
        rsp_write = r_stage_write;
        rsp_rdata = w_stage_data;
      end
      ST_TWO: begin
        rsp_valid = 1'b1;
        rsp_write = r_skid_write;
        rsp_rdata = r_skid_data;
      end
      default: ;
    endcase
  end

  // Array and its read register carry no reset so the pair maps onto one BSRAM.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      if (req_write) begin
        r_mem[req_address] <= req_wdata;
      end else begin
        r_ram_q <= r_mem[req_address];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stage_write <= 1'b0;
    end else if (w_accept) begin
      r_stage_write <= req_write;
    end
  end

  // The stage is about to be overwritten while its response is still unconsumed.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_skid_write <= 1'b0;
      r_skid_data  <= '0;
    end else if (w_accept && (r_state == ST_ONE) && !w_consume) begin
      r_skid_write <= r_stage_write;
      r_skid_data  <= w_stage_data;
    end
  end

endmodule

// File: tb/tb_sp_ram_responder.sv
// Self-checking bench for sp_ram_responder: vector table, scoreboard monitor and hand-written corner sequences.
module tb_sp_ram_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [10:0] req_address = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_write;
  logic [7:0]  rsp_rdata;

  sp_ram_responder #(.ADDR_WIDTH(11), .DATA_WIDTH(8), .INIT_BYTES(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_address(req_address),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_write  (rsp_write),
    .rsp_rdata  (rsp_rdata)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;
  int n_rsp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [10:0] a);
    return a[7:0] ^ {a[9:8], a[10:8], a[10:8]};
  endfunction

  typedef struct {
    logic       wr;
    logic [7:0] data;
    bit         known;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] model_mem [2048];
  bit         known [2048];
  bit         hold_prev = 1'b0;
  logic       hold_wr;
  logic [7:0] hold_data;

  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("hold_write", {31'd0, rsp_write}, {31'd0, hold_wr});
        chk("hold_rdata", {24'd0, rsp_rdata}, {24'd0, hold_data});
      end
      hold_prev = rsp_valid && !rsp_ready;
      hold_wr   = rsp_write;
      hold_data = rsp_rdata;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: response rdata %0h with nothing outstanding", rsp_rdata);
        end else begin
          mon_e = sb.pop_front();
          n_rsp++;
          chk("sb_write", {31'd0, rsp_write}, {31'd0, mon_e.wr});
          if (mon_e.known) chk("sb_rdata", {24'd0, rsp_rdata}, {24'd0, mon_e.data});
        end
      end
      if (req_valid && req_ready) begin
        if (req_write) begin
          model_mem[req_address] = req_wdata;
          known[req_address] = 1'b1;
          mon_e = '{1'b1, 8'h00, 1'b1};
        end else begin
          mon_e = '{1'b0, model_mem[req_address], known[req_address]};
        end
        sb.push_back(mon_e);
      end
    end
  end

  // Called 1 time unit after a rising edge; returns 1 unit after the accept edge.
  task automatic send(input logic w, input logic [10:0] a, input logic [7:0] d, output int waits);
    bit done;
    req_valid = 1'b1;
    req_write = w;
    req_address = a;
    req_wdata = d;
    waits = 0;
    done = 1'b0;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clock);
      if (req_ready) done = 1'b1;
      else waits++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: req_ready %0b for 64 cycles, expected 1", req_ready);
    end else begin
      @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !rsp_valid) break;
      @(posedge clock);
      #1;
    end
    chk("drain_outstanding", sb.size(), 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [10:0] addr;
    logic [7:0]  wdata;
    logic        exp_wr;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;

    vecs[0] = '{1'b1, 11'h123, 8'hA5, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 11'h123, 8'h00, 1'b0, 8'hA5};
    vecs[2] = '{1'b1, 11'h7FF, 8'h3C, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 11'h7FF, 8'hFF, 1'b0, 8'h3C};
    vecs[4] = '{1'b1, 11'h000, 8'h00, 1'b1, 8'h00};
    vecs[5] = '{1'b0, 11'h000, 8'h77, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 11'h123, 8'h5E, 1'b1, 8'h00};
    vecs[7] = '{1'b0, 11'h123, 8'h00, 1'b0, 8'h5E};

`ifdef SP_RAM_RESPONDER_INIT_EN
    for (int i = 0; i < 32; i++) begin
      model_mem[i] = 8'hFF;
      known[i] = 1'b1;
    end
`endif

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_write", {31'd0, rsp_write}, 32'd0);
    chk("reset_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clock);
    #1;

`ifdef SP_RAM_RESPONDER_INIT_EN
    rsp_ready = 1'b1;
    base = n_rsp;
    send(1'b0, 11'd0, 8'h00, w);
    send(1'b0, 11'd31, 8'h00, w);
    send(1'b0, 11'd32, 8'h00, w);
    drain();
    chk("init_count", n_rsp - base, 32'd3);
`endif

    // Single transactions: response must be visible in the cycle after accept.
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].wr, vecs[i].addr, vecs[i].wdata, w);
      @(negedge clock);
      chk("vec_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("vec_rsp_write", {31'd0, rsp_write}, {31'd0, vecs[i].exp_wr});
      chk("vec_rsp_rdata", {24'd0, rsp_rdata}, {24'd0, vecs[i].exp_rdata});
      @(posedge clock);
      #1;
    end
    drain();

    base = n_rsp;
    for (int a = 0; a < 2048; a++) begin
      send(1'b1, 11'(a), pat(11'(a)), w);
      chk("stream_wr_ready", w, 32'd0);
    end
    for (int a = 0; a < 2048; a++) begin
      send(1'b0, 11'(a), 8'h00, w);
      chk("stream_rd_ready", w, 32'd0);
    end
    drain();
    chk("stream_count", n_rsp - base, 32'd4096);

    rsp_ready = 1'b0;
    base = n_rsp;
    send(1'b0, 11'h010, 8'h00, w);
    chk("bp_first_wait", w, 32'd0);
    send(1'b0, 11'h011, 8'h00, w);
    chk("bp_second_wait", w, 32'd0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_address = 11'h012;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", {24'd0, rsp_rdata}, {24'd0, pat(11'h010)});
    end
    @(posedge clock);
    #1;
    rsp_ready = 1'b1;
    send(1'b0, 11'h012, 8'h00, w);
    chk("bp_resume_wait", w, 32'd1);
    drain();
    chk("bp_count", n_rsp - base, 32'd3);

    send(1'b1, 11'h055, 8'h5A, w);
    drain();
    rsp_ready = 1'b0;
    send(1'b0, 11'h020, 8'h00, w);
    send(1'b0, 11'h021, 8'h00, w);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clock);
    #1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rst_no_stale", {31'd0, rsp_valid}, 32'd0);
      @(posedge clock);
      #1;
    end
    send(1'b0, 11'h055, 8'h00, w);
    @(negedge clock);
    chk("rst_keep_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rst_keep_rdata", {24'd0, rsp_rdata}, 32'h5A);
    @(posedge clock);
    #1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
